// File: rtl/vec_seq_cpu.sv
// Lane-serial vector CPU: four vector registers, word-wide data memory, valid/ready issue,
// LPC lanes of ADD/SUB/MUL/MAC per EXEC cycle into the double-width {A4,A3} result.
module vec_seq_cpu #(
    parameter int LANES     = 16,
    parameter int LANE_W    = 32,
    parameter int LPC       = 4,
    parameter int MEM_DEPTH = 512,
    parameter int ADDR_W    = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [2:0]                instruction,
    input  logic [1:0]                reg_addr,
    input  logic [ADDR_W-1:0]         mem_address,
    input  logic [LANES*LANE_W-1:0]   initialize_value,
    output logic                      done,
    output logic [LANES*LANE_W-1:0]   A1_out,
    output logic [LANES*LANE_W-1:0]   A2_out,
    output logic [LANES*LANE_W-1:0]   A3_out,
    output logic [LANES*LANE_W-1:0]   A4_out
);

    localparam int VW     = LANES * LANE_W;
    localparam int RW     = 2 * LANE_W;
    localparam int GROUPS = LANES / LPC;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LIM_W  = ADDR_W + 1;
    localparam logic [LIM_W-1:0] DEPTH_LIMIT = LIM_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_GROUP  = CNT_W'(GROUPS - 1);

    generate
        if (LANES % LPC != 0) begin : g_bad_lpc
            $error("vec_seq_cpu: LANES must be a multiple of LPC");
        end
    endgenerate

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_MUL   = 3'b011,
        OP_INIT  = 3'b100,
        OP_SUB   = 3'b101,
        OP_MAC   = 3'b110,
        OP_NOP   = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        EXEC
    } state_t;

    state_t           state;
    opcode_t          op_in;
    opcode_t          op_r;
    logic [1:0]       tgt_r;
    logic [CNT_W-1:0] cnt;
    logic [VW-1:0]    a1, a2, a3, a4;
    logic [VW-1:0]    load_data;
    logic [VW-1:0]    sel_reg;
    logic             accept;
    logic             in_range;
    logic [MEM_AW-1:0] mem_idx;

    logic             reg_we;
    logic [1:0]       reg_wsel;
    logic [VW-1:0]    reg_wdata;

    logic signed [RW-1:0] lane_a   [LPC];
    logic signed [RW-1:0] lane_b   [LPC];
    logic signed [RW-1:0] lane_acc [LPC];
    logic signed [RW-1:0] lane_res [LPC];

    logic [VW-1:0] mem [MEM_DEPTH];

    assign op_in       = opcode_t'(instruction);
    assign instr_ready = (state == IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign in_range    = {1'b0, mem_address} < DEPTH_LIMIT;
    assign mem_idx     = MEM_AW'(mem_address);

    assign A1_out = a1;
    assign A2_out = a2;
    assign A3_out = a3;
    assign A4_out = a4;

    always_comb begin
        case (reg_addr)
            2'b00:   sel_reg = a1;
            2'b01:   sel_reg = a2;
            2'b10:   sel_reg = a3;
            default: sel_reg = a4;
        endcase
    end

    // Out-of-range stores are dropped and out-of-range loads return zero.
    always_ff @(posedge clk) begin
        if (accept && op_in == OP_STORE && in_range)
            mem[mem_idx] <= sel_reg;
        if (accept && op_in == OP_LOAD)
            load_data <= in_range ? mem[mem_idx] : '0;
    end

    always_comb begin
        reg_we    = 1'b0;
        reg_wsel  = reg_addr;
        reg_wdata = initialize_value;
        if (state == IDLE && accept && op_in == OP_INIT) begin
            reg_we = 1'b1;
        end else if (state == LOAD_WAIT) begin
            reg_we    = 1'b1;
            reg_wsel  = tgt_r;
            reg_wdata = load_data;
        end
    end

    // Per-lane operands for the current group, sign-extended to the full result width.
    always_comb begin
        for (int j = 0; j < LPC; j++) begin
            lane_a[j]   = RW'(signed'(a1[(int'(cnt) * LPC + j) * LANE_W +: LANE_W]));
            lane_b[j]   = RW'(signed'(a2[(int'(cnt) * LPC + j) * LANE_W +: LANE_W]));
            lane_acc[j] = {a4[(int'(cnt) * LPC + j) * LANE_W +: LANE_W],
                           a3[(int'(cnt) * LPC + j) * LANE_W +: LANE_W]};
            case (op_r)
                OP_ADD:  lane_res[j] = lane_a[j] + lane_b[j];
                OP_SUB:  lane_res[j] = lane_a[j] - lane_b[j];
                OP_MUL:  lane_res[j] = lane_a[j] * lane_b[j];
                OP_MAC:  lane_res[j] = lane_acc[j] + lane_a[j] * lane_b[j];
                default: lane_res[j] = lane_acc[j];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
            op_r  <= OP_NOP;
            tgt_r <= 2'b00;
            a1    <= '0;
            a2    <= '0;
            a3    <= '0;
            a4    <= '0;
        end else begin
            done <= 1'b0;

            if (reg_we) begin
                case (reg_wsel)
                    2'b00:   a1 <= reg_wdata;
                    2'b01:   a2 <= reg_wdata;
                    2'b10:   a3 <= reg_wdata;
                    default: a4 <= reg_wdata;
                endcase
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= op_in;
                        tgt_r <= reg_addr;
                        case (op_in)
                            OP_LOAD: state <= LOAD_WAIT;
                            OP_ADD, OP_SUB, OP_MUL, OP_MAC: begin
                                state <= EXEC;
                                cnt   <= '0;
                            end
                            default: done <= 1'b1;
                        endcase
                    end
                end
                LOAD_WAIT: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                EXEC: begin
                    for (int j = 0; j < LPC; j++) begin
                        a3[(int'(cnt) * LPC + j) * LANE_W +: LANE_W] <= lane_res[j][LANE_W-1:0];
                        a4[(int'(cnt) * LPC + j) * LANE_W +: LANE_W] <= lane_res[j][RW-1:LANE_W];
                    end
                    if (cnt == LAST_GROUP) begin
                        state <= IDLE;
                        cnt   <= '0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
